// File: rtl/fir_stream_dma_pkg.sv
// Shared types and constants for the FIR stream DMA.
package fir_stream_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } dma_state_e;

    localparam logic [3:0]  WB_SEL_ALL = 4'hF;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_WIDTH = 32;

    // Byte address of word idx relative to base; wraps modulo 2^32.
    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [ADDR_WIDTH-1:0] idx);
        return base + (idx * ADDR_WIDTH'(WORD_BYTES));
    endfunction

endpackage

// File: rtl/fir_stream_dma_stream_fifo.sv
// Synchronous FIFO with first-word-fall-through head; pushes when full and pops when empty are dropped.
module stream_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; simultaneous push/pop leaves count unchanged.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fir_stream_dma.sv
// Host-side stream DMA: Wishbone reads feed X into the accelerator, accelerator Y results are written back.
module fir_stream_dma
    import fir_stream_dma_pkg::*;
#(
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned LEN_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_start,
    input  logic [31:0]            cfg_src_base,
    input  logic [31:0]            cfg_dst_base,
    input  logic [LEN_WIDTH-1:0]   cfg_len,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   wbm_cyc_o,
    output logic                   wbm_stb_o,
    output logic                   wbm_we_o,
    output logic [3:0]             wbm_sel_o,
    output logic [31:0]            wbm_adr_o,
    output logic [pDATA_WIDTH-1:0] wbm_dat_o,
    input  logic [pDATA_WIDTH-1:0] wbm_dat_i,
    input  logic                   wbm_ack_i,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    input  logic                   sm_tready,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready
);
    dma_state_e             state_q, state_d;
    logic [31:0]            src_q, src_d, dst_q, dst_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   rd_cnt_q, rd_cnt_d, push_cnt_q, push_cnt_d, wr_cnt_q, wr_cnt_d;
    logic                   cyc_q, cyc_d, we_q, we_d;
    logic [31:0]            adr_q, adr_d;
    logic [pDATA_WIDTH-1:0] dat_q, dat_d;
    logic                   busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                   y_full_q, y_full_d;
    logic [pDATA_WIDTH-1:0] y_data_q, y_data_d;

    logic fifo_push, fifo_full, fifo_empty;
    logic bus_ack, x_pop, y_cap, last_y;

    stream_fifo #(
        .WIDTH (pDATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_xfifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (wbm_dat_i),
        .pop       (sm_tready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (sm_tdata)
    );

    assign sm_tvalid = ~fifo_empty;
    assign sm_tlast  = sm_tvalid & (push_cnt_q == len_q - LEN_WIDTH'(1));
    assign ss_tready = busy_q & ~y_full_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = WB_SEL_ALL;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

    assign bus_ack = cyc_q & wbm_ack_i;
    assign x_pop   = sm_tvalid & sm_tready;
    assign y_cap   = ss_tvalid & ss_tready;
    assign last_y  = (wr_cnt_q == len_q - LEN_WIDTH'(1));

    // Next-state, bus request and stream bookkeeping.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        rd_cnt_d   = rd_cnt_q;
        push_cnt_d = push_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        cyc_d      = 1'b0;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        err_d      = err_q;
        y_full_d   = y_full_q;
        y_data_d   = y_data_q;
        fifo_push  = 1'b0;

        if (x_pop) push_cnt_d = push_cnt_q + LEN_WIDTH'(1);

        // tlast must appear on exactly the Nth Y; data is kept either way.
        if (y_cap) begin
            y_full_d = 1'b1;
            y_data_d = ss_tdata;
            if (ss_tlast != last_y) err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    src_d      = cfg_src_base;
                    dst_d      = cfg_dst_base;
                    len_d      = cfg_len;
                    err_d      = 1'b0;
                    rd_cnt_d   = '0;
                    push_cnt_d = '0;
                    wr_cnt_d   = '0;
                    state_d    = (cfg_len == '0) ? ST_DONE : ST_ARB;
                end
            end
            ST_ARB: begin
                // A Y landing this cycle already wins, so the accelerator is never held off by a read.
                if (y_full_q || y_cap)                      state_d = ST_WR;
                else if ((rd_cnt_q < len_q) && !fifo_full)  state_d = ST_RD;
                else if (wr_cnt_q == len_q)                 state_d = ST_DONE;
            end
            ST_RD: begin
                we_d  = 1'b0;
                adr_d = word_addr(src_q, 32'(rd_cnt_q));
                cyc_d = ~bus_ack;
                if (bus_ack) begin
                    fifo_push = 1'b1;
                    rd_cnt_d  = rd_cnt_q + LEN_WIDTH'(1);
                    state_d   = ST_ARB;
                end
            end
            ST_WR: begin
                we_d  = 1'b1;
                adr_d = word_addr(dst_q, 32'(wr_cnt_q));
                dat_d = y_data_q;
                cyc_d = ~bus_ack;
                if (bus_ack) begin
                    y_full_d = 1'b0;
                    wr_cnt_d = wr_cnt_q + LEN_WIDTH'(1);
                    state_d  = ST_ARB;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_ARB) || (state_d == ST_RD) || (state_d == ST_WR);
        done_d = (state_q == ST_DONE);
    end

    // State and output registers; reset drops the bus cycle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            push_cnt_q <= '0;
            wr_cnt_q   <= '0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            y_full_q   <= 1'b0;
            y_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            rd_cnt_q   <= rd_cnt_d;
            push_cnt_q <= push_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            y_full_q   <= y_full_d;
            y_data_q   <= y_data_d;
        end
    end

endmodule
